// File: rtl/bcd2bin_if.sv
// bcd2bin_if: start/busy/valid handshake bundle between a requester and the bcd2bin_seq converter
interface bcd2bin_if #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  ack;
    logic [BIN_W-1:0]      bin;
    logic                  valid;
    logic                  err;
    logic                  busy;
    modport master (output start, bcd_in, ack, input bin, valid, err, busy);
    modport slave  (input start, bcd_in, ack, output bin, valid, err, busy);
endinterface

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: one-bit-per-clock reverse double-dabble BCD-to-binary converter; BCD2BIN_ACK_EN holds the result until ack
module bcd2bin_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input logic      clk,
    input logic      rst,
    bcd2bin_if.slave bus
);
    localparam int NB = 4 * DIGITS;
    localparam int CW = $clog2(NB + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] ERR   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    logic [1:0]        state;
    logic [NB-1:0]     bcd_r, bin_r, sh_bcd, sh_bin, fix_bcd;
    logic [CW-1:0]     cnt;
    logic [DIGITS-1:0] bad;
    logic [BIN_W-1:0]  bin_q;
    logic              valid_q, err_q, busy_q, accept;
    assign {sh_bcd, sh_bin} = {1'b0, bcd_r, bin_r[NB-1:1]};
    assign accept = bus.start & ~busy_q;
    genvar d;
    generate
        for (d = 0; d < DIGITS; d++) begin : g_dig
            assign fix_bcd[4*d+:4] = (sh_bcd[4*d+:4] >= 4'd8) ? sh_bcd[4*d+:4] - 4'd3 : sh_bcd[4*d+:4];
            assign bad[d]          = bus.bcd_in[4*d+:4] > 4'd9;
        end
    endgenerate
    assign bus.bin   = bin_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
    // State machine: load on accepted start, shift/correct per clock, publish result or blanking code
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bcd_r   <= '0;
            bin_r   <= '0;
            cnt     <= '0;
            bin_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt == CW'(NB)) begin
                        bin_q   <= bin_r[BIN_W-1:0];
                        err_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state   <= DONE;
`ifndef BCD2BIN_ACK_EN
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        bcd_r <= fix_bcd;
                        bin_r <= sh_bin;
                        cnt   <= cnt + 1'b1;
                    end
                end
                ERR: begin
                    bin_q   <= '1;
                    err_q   <= 1'b1;
                    valid_q <= 1'b1;
                    state   <= DONE;
`ifndef BCD2BIN_ACK_EN
                    busy_q  <= 1'b0;
`endif
                end
                DONE: begin
`ifdef BCD2BIN_ACK_EN
                    if (bus.ack) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
`else
                    valid_q <= 1'b0;
                    state   <= IDLE;
`endif
                end
                default: ;
            endcase
            if (accept) begin
                bcd_r  <= bus.bcd_in;
                bin_r  <= '0;
                cnt    <= '0;
                busy_q <= 1'b1;
                state  <= (|bad) ? ERR : SHIFT;
            end
        end
    end
endmodule
